// File: rtl/mem_bus_sequencer_pkg.sv
// Shared definitions for the memory bus sequencer: state encoding,
// bus owner codes and the wait-state counter width.
package mem_bus_sequencer_pkg;

  // Width of the wait-state counter; RAM_WAIT_STATES must fit in it (0..7).
  localparam int WAIT_CNT_WIDTH = 3;

  // Sequencer states. FETCH is the idle/default state in which the PC owns the bus.
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4
  } seq_state_t;

  // Which requester owns the current (or most recent) access.
  localparam logic OWNER_DATA = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  // Convert the wait-state parameter to a counter load value.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load_value(input int unsigned n);
    return WAIT_CNT_WIDTH'(n);
  endfunction

endpackage

// File: rtl/mem_bus_sequencer_wait_counter.sv
// Loadable down-counter that times read and write-strobe phases.
// Holds at zero; the zero flag tells the sequencer the phase is ending.
module wait_counter
  import mem_bus_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [WAIT_CNT_WIDTH-1:0] load_value,
  input  logic                      dec,
  output logic                      zero
);

  logic [WAIT_CNT_WIDTH-1:0] count_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: hands the address bus and OE/WE strobes between the
// program counter (fetch), the stage-2 transfer register and the debug port.
//
// Request handshake: a requester raises *_REQ (with *_WRITE valid alongside)
// and holds both until it sees its *_DONE high; it drops the request on the
// clock edge that ends the DONE cycle. Requests are only looked at on the
// edge that ends a FETCH cycle, so changes during an access are ignored.
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int unsigned RAM_WAIT_STATES = 1
) (
  input  logic CLK,
  input  logic RST_bar,
  input  logic DATA_REQ,
  input  logic DATA_WRITE,
  input  logic DBG_REQ,
  input  logic DBG_WRITE,
  output logic PC_ASSERT_bar,
  output logic TX_ASSERT_ADDR_bar,
  output logic DBG_ASSERT_bar,
  output logic MEM_OE_bar,
  output logic MEM_WE_bar,
  output logic STALL,
  output logic DATA_DONE,
  output logic DBG_DONE,
  output logic DBG_GNT
);

  seq_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       fair_q, fair_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       sel_dbg;
  logic       busy;
  logic       done;

  wait_counter u_wait_counter (
    .clk        (CLK),
    .rst_n      (RST_bar),
    .load       (cnt_load),
    .load_value (wait_load_value(RAM_WAIT_STATES)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State, owner and fairness registers; reset returns the bus to the PC.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q <= FETCH;
      owner_q <= OWNER_DATA;
      fair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      fair_q  <= fair_d;
    end
  end

  // Next-state, arbitration and fairness update.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    fair_d   = fair_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    sel_dbg  = 1'b0;
    done     = 1'b0;
    case (state_q)
      FETCH: begin
        if (DATA_REQ || DBG_REQ) begin
          // Debug wins alone, or on contention when it lost the last round.
          sel_dbg  = DBG_REQ && (!DATA_REQ || fair_q);
          owner_d  = sel_dbg ? OWNER_DBG : OWNER_DATA;
          state_d  = (sel_dbg ? DBG_WRITE : DATA_WRITE) ? WR_SETUP : RD;
          cnt_load = 1'b1;
        end
      end
      RD: begin
        if (cnt_zero) begin
          done    = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WR_SETUP: begin
        // Address settles with both strobes high; counter holds its load value.
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_zero) begin
          state_d = WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WR_HOLD: begin
        done    = 1'b1;
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // A data access finishing while debug waits gives debug the next turn.
    if (done) begin
      if (owner_q == OWNER_DATA) begin
        if (DBG_REQ) begin
          fair_d = 1'b1;
        end
      end else begin
        fair_d = 1'b0;
      end
    end
  end

  // Moore output decode from the registered state, owner and counter.
  always_comb begin
    busy               = (state_q != FETCH);
    PC_ASSERT_bar      = busy;
    TX_ASSERT_ADDR_bar = !(busy && (owner_q == OWNER_DATA));
    DBG_ASSERT_bar     = !(busy && (owner_q == OWNER_DBG));
    MEM_OE_bar         = (state_q == WR_SETUP) || (state_q == WR_STROBE) ||
                         (state_q == WR_HOLD);
    MEM_WE_bar         = (state_q != WR_STROBE);
    STALL              = busy;
    DATA_DONE          = ((state_q == WR_HOLD) || ((state_q == RD) && cnt_zero)) &&
                         (owner_q == OWNER_DATA);
    DBG_DONE           = ((state_q == WR_HOLD) || ((state_q == RD) && cnt_zero)) &&
                         (owner_q == OWNER_DBG);
    DBG_GNT            = busy && (owner_q == OWNER_DBG);
  end

endmodule
